// File: rtl/serdes_deserializer.sv
// ---------------------------------------------------------------------------
// serdes_deserializer
//
// Purpose:
//   Collects N_SAMPLES serial sample words, arriving one per accepted
//   valid/ready handshake, into one parallel frame. The finished frame is
//   then offered to a downstream consumer with its own valid/ready
//   handshake.
//
//   A two-state FSM controls the block:
//     COLLECT - the block accepts samples.
//     OUTPUT  - the block holds a complete frame until the consumer takes it.
//
// Parameters:
//   BIT_WIDTH - width of each sample word (default 32)
//   N_SAMPLES - samples per parallel frame, >= 1 (default 8)
//
// Ports:
//   clk       in   1                     single clock, rising edge
//   reset     in   1                     asynchronous, active-low reset
//   recv_msg  in   BIT_WIDTH             serial sample word
//   recv_val  in   1                     recv_msg valid
//   recv_rdy  out  1                     block can accept a sample
//   send_msg  out  [N_SAMPLES] x BIT_WIDTH
//                                        assembled frame; element i holds
//                                        the i-th accepted sample
//   send_val  out  1                     send_msg holds a complete frame
//   send_rdy  in   1                     consumer accepts the frame
//
// Configuration:
//   SERDES_DESERIALIZER_OVERLAP_EN - when this macro is defined, the block
//   can accept a new sample in the same cycle that the pending frame leaves.
//   In OUTPUT, recv_rdy follows send_rdy, so frames can arrive back-to-back
//   every N_SAMPLES cycles. When the macro is undefined, recv_rdy is held at
//   0 for the whole OUTPUT state.
// ---------------------------------------------------------------------------
module serdes_deserializer #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES],
  output logic                 send_val,
  input  logic                 send_rdy
);

  // The counter needs at least one bit, even when a frame has one sample.
  localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic [BIT_WIDTH-1:0] sample_q [N_SAMPLES];

  logic recv_fire;
  logic send_fire;
  logic at_last;

  // The last sample of a frame lands where the counter reaches LAST_IDX.
  // When N_SAMPLES is 1, LAST_IDX is 0, so every sample completes a frame.
  assign at_last = (count_q == LAST_IDX);

  // State register. Reset returns the block to an empty COLLECT state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs. Both ready and valid depend only on
  // the state (and on send_rdy when overlap is enabled), so recv_val never
  // reaches an output combinationally. Each fire term is formed from the
  // ready/valid value computed above it in this block.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    recv_fire = 1'b0;
    send_fire = 1'b0;

    case (state_q)
      COLLECT: begin
        recv_rdy  = 1'b1;
        recv_fire = recv_val;
        if (recv_fire) begin
          if (at_last) begin
            state_d = OUTPUT;
            count_d = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end

      OUTPUT: begin
        send_val  = 1'b1;
`ifdef SERDES_DESERIALIZER_OVERLAP_EN
        recv_rdy  = send_rdy;
`else
        recv_rdy  = 1'b0;
`endif
        send_fire = send_rdy;
        recv_fire = recv_val & recv_rdy;
        if (send_fire) begin
          state_d = COLLECT;
          count_d = '0;
          // With overlap, the incoming sample opens the next frame at
          // index 0. A one-sample frame is already complete, so the block
          // stays in OUTPUT with the new frame.
          if (recv_fire) begin
            if (N_SAMPLES == 1) begin
              state_d = OUTPUT;
            end else begin
              count_d = CW'(1);
            end
          end
        end
      end

      default: begin
        state_d = COLLECT;
        count_d = '0;
      end
    endcase
  end

  // Sample counter. Its range is 0..N_SAMPLES-1 and it never wraps past the
  // last index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Sample registers. While collecting, each accepted word goes to the slot
  // at the current count. An overlapped word, accepted in OUTPUT, always
  // goes to slot 0. The departing frame is read from these registers in the
  // same cycle, and that read is unaffected because the write takes effect
  // only after the clock edge. Slots that this frame does not write keep
  // their previous contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        sample_q[i] <= '0;
      end
    end else if (recv_fire) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        if (state_q == COLLECT) begin
          if (count_q == CW'(i)) begin
            sample_q[i] <= recv_msg;
          end
        end else if (i == 0) begin
          sample_q[i] <= recv_msg;
        end
      end
    end
  end

  assign send_msg = sample_q;

endmodule
